issue_scoreboard: RTL and testbench

Issue stage directly downstream of the instruction decoder. Holds one decoded instruction in an output register and checks register hazards against a per-register scoreboard. Dispatches the instruction to the execute stage with a valid/ready handshake. ALU results unlock after a fixed countdown; load results unlock on load writeback.

---
 rtl/issue_scoreboard.sv | 121 ++++++++++++
 tb/tb_issue_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue stage with output register and per-register hazard scoreboard
module issue_scoreboard #(
    parameter int PAYLOAD_W = 170,
    parameter int ALU_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_illegal,
    input  logic                 in_use_rsj,
    input  logic                 in_use_rsk,
    input  logic                 in_use_rsd,
    input  logic [4:0]           in_rsj,
    input  logic [4:0]           in_rsk,
    input  logic [4:0]           in_rsd,
    input  logic [1:0]           in_lockout,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_illegal,
    output logic                 out_use_rsd,
    output logic [4:0]           out_rsj,
    output logic [4:0]           out_rsk,
    output logic [4:0]           out_rsd,
    output logic [1:0]           out_lockout,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 ld_wb_valid,
    input  logic [4:0]           ld_wb_rd,
    input  logic                 flush
);

    logic [2:0]  r_alu_cnt [1:31];
    logic        r_ld_pend [1:31];
    logic [31:0] w_busy;
    logic        w_haz_j;
    logic        w_haz_k;
    logic        w_haz_d;
    logic        w_hazard;
    logic        w_accept;
    logic        w_dispatch;
    logic        w_set_en;
    logic        w_set_alu;
    logic        w_set_ld;

    // The held instruction has not reached the scoreboard yet, so it is matched directly.
    function automatic logic held_match(input logic [4:0] a);
        return out_valid & out_use_rsd & (out_lockout != 2'b00) &
               (out_rsd == a) & (out_rsd != 5'd0);
    endfunction

    always_comb begin
        w_busy = '0;
        for (int r = 1; r < 32; r++) begin
            w_busy[r] = (r_alu_cnt[r] != 3'd0) | r_ld_pend[r];
        end
    end

    assign w_haz_j  = in_use_rsj & (in_rsj != 5'd0) & (w_busy[in_rsj] | held_match(in_rsj));
    assign w_haz_k  = in_use_rsk & (in_rsk != 5'd0) & (w_busy[in_rsk] | held_match(in_rsk));
    assign w_haz_d  = in_use_rsd & (in_rsd != 5'd0) & (w_busy[in_rsd] | held_match(in_rsd));
    assign w_hazard = ~in_illegal & (w_haz_j | w_haz_k | w_haz_d);

    assign in_ready   = rstn & ~flush & ~w_hazard & (~out_valid | out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_dispatch = out_valid & out_ready & ~flush;

    assign w_set_en  = w_dispatch & out_use_rsd & (out_rsd != 5'd0) & ~out_illegal;
    assign w_set_alu = w_set_en & (out_lockout == 2'b01);
    assign w_set_ld  = w_set_en & out_lockout[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            out_use_rsd <= 1'b0;
            out_rsj     <= '0;
            out_rsk     <= '0;
            out_rsd     <= '0;
            out_lockout <= '0;
            out_payload <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid   <= 1'b1;
            out_illegal <= in_illegal;
            out_use_rsd <= in_use_rsd;
            out_rsj     <= in_rsj;
            out_rsk     <= in_rsk;
            out_rsd     <= in_rsd;
            out_lockout <= in_lockout;
            out_payload <= in_payload;
        end else if (w_dispatch) begin
            out_valid <= 1'b0;
        end
    end

    // A dispatch-set beats a same-cycle writeback clear or countdown on the same register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 1; r < 32; r++) begin
                r_alu_cnt[r] <= 3'd0;
                r_ld_pend[r] <= 1'b0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (w_set_alu && (out_rsd == 5'(r))) begin
                    r_alu_cnt[r] <= 3'(ALU_LAT);
                end else if (r_alu_cnt[r] != 3'd0) begin
                    r_alu_cnt[r] <= r_alu_cnt[r] - 3'd1;
                end
                if (w_set_ld && (out_rsd == 5'(r))) begin
                    r_ld_pend[r] <= 1'b1;
                end else if (ld_wb_valid && (ld_wb_rd == 5'(r))) begin
                    r_ld_pend[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - scoreboard-checked directed bench for issue_scoreboard
module tb_issue_scoreboard;

    localparam int PW = 170;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic          in_illegal;
    logic          in_use_rsj;
    logic          in_use_rsk;
    logic          in_use_rsd;
    logic [4:0]    in_rsj;
    logic [4:0]    in_rsk;
    logic [4:0]    in_rsd;
    logic [1:0]    in_lockout;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic          out_illegal;
    logic          out_use_rsd;
    logic [4:0]    out_rsj;
    logic [4:0]    out_rsk;
    logic [4:0]    out_rsd;
    logic [1:0]    out_lockout;
    logic [PW-1:0] out_payload;
    logic          ld_wb_valid;
    logic [4:0]    ld_wb_rd;
    logic          flush;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q [$];

    issue_scoreboard #(.PAYLOAD_W(PW), .ALU_LAT(2)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_illegal(in_illegal),
        .in_use_rsj(in_use_rsj), .in_use_rsk(in_use_rsk), .in_use_rsd(in_use_rsd),
        .in_rsj(in_rsj), .in_rsk(in_rsk), .in_rsd(in_rsd),
        .in_lockout(in_lockout), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_illegal(out_illegal),
        .out_use_rsd(out_use_rsd), .out_rsj(out_rsj), .out_rsk(out_rsk),
        .out_rsd(out_rsd), .out_lockout(out_lockout), .out_payload(out_payload),
        .ld_wb_valid(ld_wb_valid), .ld_wb_rd(ld_wb_rd), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mkpay(input int tag);
        return {8'hA5, 146'd0, tag[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int tag, input bit uj, input logic [4:0] rj,
                         input bit uk, input logic [4:0] rk, input bit ud,
                         input logic [4:0] rd, input logic [1:0] lk, input bit ill);
        in_valid   = 1'b1;
        in_payload = mkpay(tag);
        in_use_rsj = uj;  in_rsj = rj;
        in_use_rsk = uk;  in_rsk = rk;
        in_use_rsd = ud;  in_rsd = rd;
        in_lockout = lk;  in_illegal = ill;
    endtask

    // Presents one instruction, counts stall cycles until accepted, checks that count.
    task automatic issue(input string nm, input int tag, input bit uj, input logic [4:0] rj,
                         input bit uk, input logic [4:0] rk, input bit ud,
                         input logic [4:0] rd, input logic [1:0] lk, input bit ill,
                         input int exp_wait, input bit push);
        int waited;
        waited = 0;
        drive(tag, uj, rj, uk, rk, ud, rd, lk, ill);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 60) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) exp_q.push_back(mkpay(tag));
        chk(nm, PW'(waited), PW'(exp_wait));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every dispatch must match the oldest expected payload.
    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dispatch: got %0h expected none", out_payload);
                end else begin
                    e = exp_q.pop_front();
                    chk("dispatch_payload", out_payload, e);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; out_ready = 1'b1; flush = 1'b0;
        ld_wb_valid = 1'b0; ld_wb_rd = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        #2;
        chk("reset_in_ready", PW'(in_ready), '0);
        chk("reset_out_valid", PW'(out_valid), '0);
        chk("reset_out_payload", out_payload, '0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        in_valid = 1'b0;

        // Mid-stream reset with x5 counting down and an instruction held
        issue("rst_w5", 1, 0, 0, 0, 0, 1, 5, 2'b01, 0, 0, 1);
        issue("rst_hold", 2, 0, 0, 0, 0, 1, 6, 2'b00, 0, 0, 0);
        out_ready = 1'b0;
        #1;
        rstn = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("midrst_out_valid", PW'(out_valid), '0);
        chk("midrst_out_payload", out_payload, '0);
        chk("midrst_out_rsd", PW'(out_rsd), '0);
        chk("midrst_in_ready", PW'(in_ready), '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        issue("rst_rd5_nostall", 3, 1, 5, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        idle(3);

        // ALU lockout: RAW on rsj and rsk, illegal bypass, full throughput
        issue("alu_w5", 10, 0, 0, 0, 0, 1, 5, 2'b01, 0, 0, 1);
        issue("alu_raw_rsj", 11, 1, 5, 0, 0, 0, 0, 2'b00, 0, 3, 1);
        issue("alu_w14", 12, 0, 0, 0, 0, 1, 14, 2'b01, 0, 0, 1);
        issue("illegal_bypass", 13, 1, 14, 0, 0, 0, 0, 2'b00, 1, 0, 1);
        issue("alu_raw_rsk", 14, 0, 0, 1, 14, 0, 0, 2'b00, 0, 2, 1);
        issue("ill_w15", 15, 0, 0, 0, 0, 1, 15, 2'b01, 1, 0, 1);
        issue("ill_no_sb", 16, 1, 15, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        for (int i = 0; i < 4; i++)
            issue("b2b", 20 + i, 1, 5'd25, 0, 0, 1, 5'(16 + i), 2'b01, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            issue("x0_never", 30 + i, 1, 0, 1, 0, 1, 0, 2'b01, 0, 0, 1);
        idle(4);

        // Load lockout; writeback to x8 must not unblock x7
        issue("ld_w7", 40, 0, 0, 0, 0, 1, 7, 2'b10, 0, 0, 1);
        fork
            issue("ld_raw7", 41, 1, 7, 0, 0, 0, 0, 2'b00, 0, 8, 1);
            begin
                repeat (3) @(posedge clk);
                #1; ld_wb_valid = 1'b1; ld_wb_rd = 5'd8;
                @(posedge clk);
                #1; ld_wb_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1; ld_wb_valid = 1'b1; ld_wb_rd = 5'd7;
                @(posedge clk);
                #1; ld_wb_valid = 1'b0;
            end
        join
        idle(2);

        // Backpressure
        issue("bp_p", 50, 0, 0, 0, 0, 1, 20, 2'b00, 0, 0, 1);
        out_ready = 1'b0;
        drive(51, 0, 0, 0, 0, 1, 21, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_payload", out_payload, mkpay(50));
            chk("bp_rsd", PW'(out_rsd), PW'(20));
            chk("bp_in_ready", PW'(in_ready), '0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("bp_q_same_cycle", 51, 0, 0, 0, 0, 1, 21, 2'b00, 0, 0, 1);
        idle(2);

        // Flush drops a held load with out_ready=1
        issue("fl_ld9", 60, 0, 0, 0, 0, 1, 9, 2'b10, 0, 0, 0);
        flush = 1'b1;
        drive(61, 0, 0, 0, 0, 1, 22, 2'b00, 0);
        @(negedge clk);
        chk("flush_in_ready", PW'(in_ready), '0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", PW'(out_valid), '0);
        issue("fl_rd9_free", 62, 1, 9, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        idle(2);

        // Same-cycle writeback clear and dispatch-set of x4: set wins
        issue("ld_w4", 70, 0, 0, 0, 0, 1, 4, 2'b10, 0, 0, 1);
        fork
            begin
                issue("waw_x4", 71, 0, 0, 0, 0, 1, 4, 2'b11, 0, 3, 1);
                issue("set_wins_x4", 72, 1, 4, 0, 0, 0, 0, 2'b00, 0, 5, 1);
            end
            begin
                repeat (2) @(posedge clk);
                #1; ld_wb_valid = 1'b1; ld_wb_rd = 5'd4;
                @(posedge clk);
                #1; ld_wb_valid = 1'b0;
                @(posedge clk);
                #1; ld_wb_valid = 1'b1;
                @(posedge clk);
                #1; ld_wb_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1; ld_wb_valid = 1'b1;
                @(posedge clk);
                #1; ld_wb_valid = 1'b0;
            end
        join
        idle(4);

        chk("all_dispatched", PW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
